// File: rtl/wb_burst_reader_pkg.sv
// Shared definitions for the Wishbone burst reader: cycle-type and burst-type codes,
// the controller state encoding and a small helper used to size bursts.
package wb_burst_reader_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSpace,
    StBurst,
    StDrain
  } state_e;

  function automatic logic [15:0] min_u16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/wb_burst_fifo.sv
// Synchronous show-ahead FIFO used to buffer read beats for the stream side.
// Ports:
//   clk, rst     clock, synchronous active-high reset (flushes contents)
//   push, wdata  write request and data
//   pop          read request; rdata always shows the oldest entry
//   rdata        head-of-queue data (valid when !empty)
//   full, empty  occupancy flags
//   free         number of unoccupied entries
module wb_burst_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 32,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] free
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW-1:0] wr_ptr_next, rd_ptr_next;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign free  = CW'(DEPTH) - count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign wr_ptr_next = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
  assign rd_ptr_next = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_next;
      if (do_pop)  rd_ptr_q <= rd_ptr_next;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone B3 master that reads a word-aligned region using incrementing linear bursts
// and forwards the words on a valid/ready stream through an internal FIFO.
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   start_i, base_adr_i, len_i  transfer request (byte address, length in words)
//   busy_o, done_o, err_o     status: busy, one-cycle done pulse, sticky bus error
//   wbm_*                     Wishbone B3 master interface (read only)
//   m_data_o, m_valid_o, m_ready_i  show-ahead output stream
module wb_burst_reader
  import wb_burst_reader_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            start_i,
  input  logic [AW-1:0]   base_adr_i,
  input  logic [15:0]     len_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic            wbm_we_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic [2:0]      wbm_cti_o,
  output logic [1:0]      wbm_bte_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  input  logic            wbm_rty_i,
  output logic [DW-1:0]   m_data_o,
  output logic            m_valid_o,
  input  logic            m_ready_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(BURST_LEN) + 1;

  state_e        state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [15:0]   rem_q, rem_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          cyc_q, cyc_d;
  logic [2:0]    cti_q, cti_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          fifo_push, fifo_empty, fifo_full;
  logic [CW-1:0] fifo_free;
  logic [15:0]   beats;
  logic          bus_err;

  // Byte-lane bits of the base address are dropped; the region is always word aligned.
  logic unused_base_lsbs;
  assign unused_base_lsbs = ^base_adr_i[1:0];

  assign beats   = min_u16(rem_q, 16'(BURST_LEN));
  assign bus_err = cyc_q && (wbm_err_i || wbm_rty_i);

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    rem_d     = rem_q;
    beat_d    = beat_q;
    cyc_d     = cyc_q;
    cti_d     = cti_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    fifo_push = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          adr_d   = {base_adr_i[AW-1:2], 2'b00};
          rem_d   = len_i;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = (len_i == 16'd0) ? StDrain : StWaitSpace;
        end
      end
      StWaitSpace: begin
        // Reserve room for the whole burst up front so acks never meet a full FIFO.
        if (16'(fifo_free) >= beats) begin
          cyc_d   = 1'b1;
          beat_d  = BW'(beats);
          cti_d   = (beats == 16'd1) ? CTI_EOB : CTI_INC;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (bus_err) begin
          cyc_d   = 1'b0;
          cti_d   = CTI_CLASSIC;
          err_d   = 1'b1;
          rem_d   = 16'd0;
          state_d = StDrain;
        end else if (wbm_ack_i) begin
          fifo_push = 1'b1;
          adr_d     = adr_q + AW'(4);
          rem_d     = rem_q - 16'd1;
          beat_d    = beat_q - BW'(1);
          if (beat_q == BW'(1)) begin
            cyc_d   = 1'b0;
            cti_d   = CTI_CLASSIC;
            state_d = (rem_q == 16'd1) ? StDrain : StWaitSpace;
          end else if (beat_q == BW'(2)) begin
            cti_d = CTI_EOB;
          end
        end
      end
      StDrain: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      adr_q   <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      cyc_q   <= 1'b0;
      cti_q   <= CTI_CLASSIC;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      cyc_q   <= cyc_d;
      cti_q   <= cti_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  wb_burst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DW),
    .CW    (CW)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (fifo_push),
    .wdata (wbm_dat_i),
    .pop   (m_ready_i),
    .rdata (m_data_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .free  (fifo_free)
  );

  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign wbm_adr_o = adr_q;
  assign wbm_sel_o = '1;
  assign wbm_we_o  = 1'b0;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_cti_o = cti_q;
  assign wbm_bte_o = BTE_LINEAR;
  assign m_valid_o = !fifo_empty;

endmodule

// File: tb/tb_wb_burst_reader.sv
module tb_wb_burst_reader;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BL = 8;
  localparam int unsigned FD = 16;

  logic          clk, rst, start;
  logic [AW-1:0] base_adr;
  logic [15:0]   len_r;
  logic          busy, done, err;
  logic [AW-1:0] adr;
  logic [3:0]    sel;
  logic          we, cyc, stb;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic [DW-1:0] dat;
  logic          ack, berr, rty;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready;

  wb_burst_reader #(
    .AW(AW), .DW(DW), .BURST_LEN(BL), .FIFO_DEPTH(FD)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .base_adr_i(base_adr), .len_i(len_r),
    .busy_o(busy), .done_o(done), .err_o(err),
    .wbm_adr_o(adr), .wbm_sel_o(sel), .wbm_we_o(we), .wbm_cyc_o(cyc), .wbm_stb_o(stb),
    .wbm_cti_o(cti), .wbm_bte_o(bte), .wbm_dat_i(dat), .wbm_ack_i(ack), .wbm_err_i(berr),
    .wbm_rty_i(rty), .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Stimulus knobs (written by the main thread)
  int ack_pct   = 100;
  int ready_pct = 100;
  int err_beat  = -1;
  bit use_rty   = 0;
  bit rdy_mode  = 0;   // 1: ready only while budget > 0
  int budget    = 0;

  // Reference model
  logic [31:0] exp_adr[$];
  logic [31:0] exp_data[$];
  int          total = 0;
  bit          model_err = 0;
  bit          expect_cyc_low = 0;
  int          acks = 0, eob_acks = 0, delivered = 0;
  bit          saw_zero = 0, first_pending = 0;
  logic [31:0] first_data = '0;

  function automatic logic [2:0] exp_cti();
    int idx;
    idx = total - exp_adr.size();
    if ((idx % BL) == BL - 1 || idx == total - 1) return 3'b111;
    return 3'b010;
  endfunction

  always begin
    @(negedge clk);
    chk("m_valid", m_valid, exp_data.size() != 0);
    if (m_valid && exp_data.size() != 0) chk("m_data", m_data, exp_data[0]);
    chk("err_o", err, model_err);
    chk("static_bus", {we, sel, bte, stb}, {1'b0, 4'hF, 2'b00, cyc});
    chk("fifo_bound", exp_data.size() <= FD, 1'b1);
    if (expect_cyc_low) begin
      chk("cyc_after_err", cyc, 1'b0);
      expect_cyc_low = 0;
    end
    if (exp_adr.size() == 0) chk("cyc_idle", cyc, 1'b0);
    else if (cyc) begin
      chk("adr", adr, exp_adr[0]);
      chk("cti", cti, exp_cti());
    end
    #2;
    ack  = 1'b0;
    berr = 1'b0;
    rty  = 1'b0;
    dat  = mem_word(adr);
    if (cyc && stb) begin
      if (acks == err_beat) begin
        if (use_rty) rty = 1'b1;
        else berr = 1'b1;
      end else if ($urandom_range(99) < ack_pct) ack = 1'b1;
    end
    m_ready = rdy_mode ? (budget > 0) : ($urandom_range(99) < ready_pct);
    if (rst) begin
      exp_adr.delete();
      exp_data.delete();
      model_err = 0;
      expect_cyc_low = 0;
      total = 0;
    end else begin
      if (m_valid && m_ready && exp_data.size() != 0) begin
        if (first_pending) begin
          first_data = exp_data[0];
          first_pending = 0;
        end
        void'(exp_data.pop_front());
        delivered++;
        if (rdy_mode && budget > 0) budget--;
      end
      if (cyc && (berr || rty)) begin
        model_err = 1;
        exp_adr.delete();
        expect_cyc_low = 1;
      end else if (cyc && stb && ack && exp_adr.size() != 0) begin
        if (exp_cti() == 3'b111) eob_acks++;
        if (exp_adr[0] == 32'h0) saw_zero = 1;
        exp_data.push_back(mem_word(exp_adr.pop_front()));
        acks++;
      end
      if (start) begin
        exp_adr.delete();
        for (int i = 0; i < int'(len_r); i++)
          exp_adr.push_back({base_adr[31:2], 2'b00} + 32'(4 * i));
        total = int'(len_r);
        model_err = 0;
        acks = 0;
        eob_acks = 0;
        delivered = 0;
        saw_zero = 0;
        first_pending = 1;
      end
    end
  end

  task automatic start_xfer(input logic [31:0] b, input logic [15:0] l);
    @(negedge clk);
    base_adr = b;
    len_r = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (n < 4000 && !seen) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    chk({name, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      chk({name, "_busy_at_done"}, busy, 1'b0);
      @(negedge clk);
      chk({name, "_done_pulse"}, done, 1'b0);
    end
  endtask

  initial begin
    int l, eb;
    rst = 1'b1; start = 1'b0; base_adr = '0; len_r = '0;
    ack = 0; berr = 0; rty = 0; dat = '0; m_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", {cyc, stb, busy, done, err, m_valid, cti, bte}, 11'h0);
    chk("rst_adr", adr, 32'h0);
    rst = 1'b0;

    // 1) single 8-beat burst, zero-wait, always ready
    start_xfer(32'h100, 16'd8);
    chk("t1_busy", busy, 1'b1);
    chk("t1_cyc_n", cyc, 1'b0);
    @(negedge clk);
    chk("t1_cyc_n1", {cyc, cti}, {1'b1, 3'b010});
    chk("t1_adr0", adr, 32'h100);
    wait_done("t1");
    chk("t1_words", delivered, 8);
    chk("t1_first", first_data, 32'hDEAD_0100);
    chk("t1_eob", eob_acks, 1);

    // 2) back-pressure: 20 words with stalled consumer
    rdy_mode = 1; budget = 0;
    start_xfer(32'h2000, 16'd20);
    repeat (60) @(negedge clk);
    chk("t2_acks_full", acks, 16);
    chk("t2_hold", {cyc, m_valid}, 2'b01);
    budget = 3;
    repeat (20) @(negedge clk);
    chk("t2_acks_3free", acks, 16);
    budget = 1;
    repeat (20) @(negedge clk);
    chk("t2_acks_4free", acks, 20);
    rdy_mode = 0; ready_pct = 100;
    wait_done("t2");
    chk("t2_words", delivered, 20);
    chk("t2_eob", eob_acks, 3);

    // 3) len=1 and len=0
    start_xfer(32'h3001, 16'd1);
    @(negedge clk);
    chk("t3_single", {cyc, cti, adr}, {1'b1, 3'b111, 32'h3000});
    wait_done("t3a");
    chk("t3_words1", delivered, 1);
    start_xfer(32'h3100, 16'd0);
    chk("t3_len0_n", {busy, done}, 2'b10);
    @(negedge clk);
    chk("t3_len0_done", {busy, done}, 2'b01);
    @(negedge clk);
    chk("t3_len0_pulse", done, 1'b0);

    // 4) bus error on the third beat
    err_beat = 2; use_rty = 0;
    start_xfer(32'h400, 16'd8);
    wait_done("t4");
    chk("t4_words", delivered, 2);
    chk("t4_err", err, 1'b1);
    err_beat = -1;
    start_xfer(32'h500, 16'd4);
    chk("t4_err_clr", err, 1'b0);
    wait_done("t4b");
    chk("t4b_words", delivered, 4);

    // 5) reset mid-burst with data buffered
    rdy_mode = 1; budget = 0;
    start_xfer(32'h800, 16'd16);
    repeat (4) @(negedge clk);
    chk("t5_mid", cyc, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_after_rst", {cyc, stb, m_valid, busy, err, cti}, 8'h0);
    chk("t5_adr", adr, 32'h0);
    rst = 1'b0;
    rdy_mode = 0; ready_pct = 100;
    start_xfer(32'h900, 16'd5);
    wait_done("t5b");
    chk("t5b_words", delivered, 5);

    // 6) random stalls with address wrap, then a few random transfers
    ack_pct = 60; ready_pct = 50;
    start_xfer(32'hFFFF_FFF0, 16'd37);
    wait_done("t6");
    chk("t6_words", delivered, 37);
    chk("t6_wrap", saw_zero, 1'b1);
    for (int i = 0; i < 4; i++) begin
      l = $urandom_range(1, 30);
      eb = (i == 3) ? $urandom_range(0, l - 1) : -1;
      err_beat = eb; use_rty = 1;
      ack_pct = $urandom_range(30, 100); ready_pct = $urandom_range(20, 100);
      start_xfer($urandom, 16'(l));
      wait_done("t6r");
      chk("t6r_words", delivered, (eb >= 0) ? eb : l);
      chk("t6r_err", err, eb >= 0);
    end
    err_beat = -1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
